// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the EX forwarding muxes and mult_div_unit.
// The EX stage is the master; the multiply/divide unit is the slave.
interface mult_div_unit_if #(
  parameter int NB_DATA = 32
);
  logic [NB_DATA-1:0] op1_i;
  logic [NB_DATA-1:0] op2_i;
  logic               start_i;
  logic [1:0]         op_i;
  logic               mthi_i;
  logic               mtlo_i;
  logic [NB_DATA-1:0] hi_o;
  logic [NB_DATA-1:0] lo_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output op1_i, op2_i, start_i, op_i, mthi_i, mtlo_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  op1_i, op2_i, start_i, op_i, mthi_i, mtlo_i,
    output hi_o, lo_o, busy_o, done_o
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on operand magnitudes for NB_DATA cycles, then applies sign correction in FIX.
module mult_div_unit #(
  parameter int NB_DATA = 32
) (
  input  logic            clock_i,
  input  logic            reset_i,
  mult_div_unit_if.slave  bus
);

  localparam int NB_CNT = $clog2(NB_DATA);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_next;

  logic [NB_CNT-1:0]    count;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0_q;
  logic [NB_DATA-1:0]   raw_op1_q;
  logic [NB_DATA-1:0]   opb_q;
  logic [2*NB_DATA-1:0] acc_q;
  logic [NB_DATA-1:0]   hi_q;
  logic [NB_DATA-1:0]   lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 sign1, sign2;
  logic [NB_DATA-1:0]   mag1, mag2;
  logic [NB_DATA-1:0]   mul_addend;
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] mul_next;
  logic [NB_DATA:0]     rem_shift;
  logic                 q_bit;
  logic [NB_DATA-1:0]   rem_new;
  logic [2*NB_DATA-1:0] div_next;
  logic [2*NB_DATA-1:0] mul_res;
  logic [NB_DATA-1:0]   quo, rem;
  logic [NB_DATA-1:0]   fix_hi, fix_lo;

  always_ff @(posedge clock_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_i) state_next = RUN;
      RUN:     if (count == NB_CNT'(NB_DATA - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Start decode: op_i[0]==0 selects the signed variants, which run on magnitudes.
  always_comb begin
    sign1 = ~bus.op_i[0] & bus.op1_i[NB_DATA-1];
    sign2 = ~bus.op_i[0] & bus.op2_i[NB_DATA-1];
    mag1  = sign1 ? -bus.op1_i : bus.op1_i;
    mag2  = sign2 ? -bus.op2_i : bus.op2_i;
  end

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[NB_DATA-1:1]};
  end

  // Restoring divide: acc = {remainder, dividend bits shifting out / quotient bits in}.
  always_comb begin
    rem_shift = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
    q_bit     = (rem_shift >= {1'b0, opb_q});
    rem_new   = q_bit ? NB_DATA'(rem_shift - {1'b0, opb_q}) : rem_shift[NB_DATA-1:0];
    div_next  = {rem_new, acc_q[NB_DATA-2:0], q_bit};
  end

  always_comb begin
    mul_res = neg_q ? -acc_q : acc_q;
    quo     = acc_q[NB_DATA-1:0];
    rem     = acc_q[2*NB_DATA-1:NB_DATA];
    fix_lo  = div0_q ? '1        : (neg_q ? -quo : quo);
    fix_hi  = div0_q ? raw_op1_q : (neg_r ? -rem : rem);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      count     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0_q    <= 1'b0;
      raw_op1_q <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.mthi_i) hi_q <= bus.op1_i;
          if (bus.mtlo_i) lo_q <= bus.op1_i;
          if (bus.start_i) begin
            count     <= '0;
            op_q      <= bus.op_i;
            neg_q     <= sign1 ^ sign2;
            neg_r     <= sign1;
            div0_q    <= bus.op_i[1] && (bus.op2_i == '0);
            raw_op1_q <= bus.op1_i;
            opb_q     <= bus.op_i[1] ? mag2 : mag1;
            acc_q     <= {{NB_DATA{1'b0}}, (bus.op_i[1] ? mag1 : mag2)};
          end
        end
        RUN: begin
          acc_q <= op_q[1] ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          hi_q <= op_q[1] ? fix_hi : mul_res[2*NB_DATA-1:NB_DATA];
          lo_q <= op_q[1] ? fix_lo : mul_res[NB_DATA-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: results, latency, MTHI/MTLO,
// ignored requests during RUN, reset abort and back-to-back issue.
module tb_mult_div_unit;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mult_div_unit_if #(.NB_DATA(32)) bus();

  mult_div_unit #(.NB_DATA(32)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_i    = op;
    bus.op1_i   = a;
    bus.op2_i   = b;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  // Counts edges after the start edge until done_o is seen; 33 is the expected latency.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (bus.done_o !== 1'b1 && lat < 100) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    if (lat >= 100) check_output("done_timeout", {63'b0, bus.done_o}, 64'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat, bc;
    apply_stimulus(op, a, b);
    wait_done(lat, bc);
    check_output({tag, "_latency"}, 64'(lat), 64'd33);
    check_output({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check_output({tag, "_hi"}, {32'b0, bus.hi_o}, {32'b0, exp_hi});
    check_output({tag, "_lo"}, {32'b0, bus.lo_o}, {32'b0, exp_lo});
    step();
    check_output({tag, "_done_one_cycle"}, {63'b0, bus.done_o}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bc, done_seen;

    reset       = 1'b0;
    bus.op1_i   = '0;
    bus.op2_i   = '0;
    bus.op_i    = '0;
    bus.start_i = 1'b0;
    bus.mthi_i  = 1'b0;
    bus.mtlo_i  = 1'b0;
    step();
    step();
    check_output("reset_hi", {32'b0, bus.hi_o}, 64'd0);
    check_output("reset_lo", {32'b0, bus.lo_o}, 64'd0);
    check_output("reset_busy", {63'b0, bus.busy_o}, 64'd0);
    check_output("reset_done", {63'b0, bus.done_o}, 64'd0);
    reset = 1'b1;
    step();

    run_and_check("mult_m1x2",    OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_and_check("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_and_check("div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_and_check("divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    run_and_check("div_by_zero",  OP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
    run_and_check("div_overflow", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    bus.op1_i  = 32'hAAAA0000;
    bus.mthi_i = 1'b1;
    step();
    bus.mthi_i = 1'b0;
    check_output("mthi_hi", {32'b0, bus.hi_o}, 64'h00000000_AAAA0000);
    check_output("mthi_lo_kept", {32'b0, bus.lo_o}, 64'h00000000_80000000);

    // MTLO and a second start in the middle of RUN must both be ignored.
    apply_stimulus(OP_MULTU, 32'd3, 32'd5);
    step();
    step();
    step();
    bus.mtlo_i  = 1'b1;
    bus.op1_i   = 32'h55555555;
    bus.op2_i   = 32'h00000001;
    bus.op_i    = OP_DIVU;
    bus.start_i = 1'b1;
    step();
    bus.mtlo_i  = 1'b0;
    bus.start_i = 1'b0;
    check_output("mtlo_in_run_lo", {32'b0, bus.lo_o}, 64'h00000000_80000000);
    check_output("mthi_kept_in_run", {32'b0, bus.hi_o}, 64'h00000000_AAAA0000);
    wait_done(lat, bc);
    check_output("restart_in_run_latency", 64'(lat + 4), 64'd33);
    check_output("restart_in_run_hi", {32'b0, bus.hi_o}, 64'd0);
    check_output("restart_in_run_lo", {32'b0, bus.lo_o}, 64'd15);
    step();

    bus.op1_i  = 32'h13572468;
    bus.mthi_i = 1'b1;
    bus.mtlo_i = 1'b1;
    step();
    bus.mthi_i = 1'b0;
    bus.mtlo_i = 1'b0;
    check_output("mthi_mtlo_hi", {32'b0, bus.hi_o}, 64'h00000000_13572468);
    check_output("mthi_mtlo_lo", {32'b0, bus.lo_o}, 64'h00000000_13572468);

    // Abort a MULT at iteration 10 with reset.
    apply_stimulus(OP_MULT, 32'h00001234, 32'h00000010);
    repeat (10) step();
    check_output("abort_busy_before", {63'b0, bus.busy_o}, 64'd1);
    reset = 1'b0;
    step();
    check_output("abort_busy", {63'b0, bus.busy_o}, 64'd0);
    check_output("abort_hi", {32'b0, bus.hi_o}, 64'd0);
    check_output("abort_lo", {32'b0, bus.lo_o}, 64'd0);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      if (bus.done_o === 1'b1) done_seen++;
      step();
    end
    check_output("abort_no_done", 64'(done_seen), 64'd0);
    check_output("abort_hi_after", {32'b0, bus.hi_o}, 64'd0);

    apply_stimulus(OP_DIVU, 32'd9, 32'd3);
    wait_done(lat, bc);
    check_output("b2b_first_latency", 64'(lat), 64'd33);
    check_output("b2b_first_lo", {32'b0, bus.lo_o}, 64'd3);
    check_output("b2b_first_hi", {32'b0, bus.hi_o}, 64'd0);
    check_output("b2b_done_high", {63'b0, bus.done_o}, 64'd1);
    apply_stimulus(OP_DIVU, 32'd10, 32'd3);
    check_output("b2b_second_accepted", {63'b0, bus.busy_o}, 64'd1);
    wait_done(lat, bc);
    check_output("b2b_second_latency", 64'(lat), 64'd33);
    check_output("b2b_second_lo", {32'b0, bus.lo_o}, 64'd3);
    check_output("b2b_second_hi", {32'b0, bus.hi_o}, 64'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
